// File: rtl/ad9866_pkg.sv
// Shared definitions for the AD9866 SPI responder: register-file geometry,
// frame field positions, reset contents of the register map and FSM states.
package ad9866_pkg;

   localparam int unsigned AD9866_NREGS = 32;
   localparam int unsigned FRAME_BITS   = 16;
   localparam int unsigned RW_BIT       = 15;
   localparam int unsigned ADDR_MSB     = 12;
   localparam int unsigned ADDR_LSB     = 8;
   localparam int unsigned ADDR_W       = 5;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned CNT_W        = 5;

   // Register map contents after reset, indexed by address
   localparam logic [7:0] AD9866_REG_RST [0:31] = '{
      8'h80, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00,
      8'h00, 8'hF0, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/ad9866_spi_sync.sv
// Input synchroniser for the SPI pins plus sclk edge detection.
// Ports: clk, rst_n (sync, active low); sclk/sen_n/sdio raw pins in;
//        sen_s/sdio_s synchronised levels; rise_c/fall_c one-clk sclk edge
//        pulses, combinational off the synchroniser outputs.
module ad9866_spi_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic sen_n,
   input  logic sdio,
   output logic sen_s,
   output logic sdio_s,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] sen_sr;
   logic [SYNC_STAGES-1:0] sdio_sr;
   logic                   sclk_d;

   // Synchroniser chains; sen_n resets to its inactive (high) level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sr <= '0;
         sen_sr  <= '1;
         sdio_sr <= '0;
         sclk_d  <= 1'b0;
      end else begin
         sclk_sr[0] <= sclk;
         sen_sr[0]  <= sen_n;
         sdio_sr[0] <= sdio;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sr[i] <= sclk_sr[i-1];
            sen_sr[i]  <= sen_sr[i-1];
            sdio_sr[i] <= sdio_sr[i-1];
         end
         sclk_d <= sclk_sr[SYNC_STAGES-1];
      end
   end

   assign sen_s  = sen_sr[SYNC_STAGES-1];
   assign sdio_s = sdio_sr[SYNC_STAGES-1];
   assign rise_c = sclk_sr[SYNC_STAGES-1] & ~sclk_d;
   assign fall_c = ~sclk_sr[SYNC_STAGES-1] & sclk_d;

endmodule

// File: rtl/ad9866_spi_slave.sv
// AD9866 serial-port responder: decodes 16-bit R/nW frames oversampled on clk,
// holds a 32x8 register file and returns read data on sdo.
// Ports: clk, rst_n (sync, active low); sclk/sen_n/sdio SPI pins in;
//        sdo/sdo_oe read data out; wr_stb/wr_addr/wr_data write notification;
//        frame_err aborted-frame pulse; regs_o flat register file.
// Build option: define AD9866_SLV_DCCAL_EN to make reg 0x07 bit0 self-clear
// CAL_CYCLES clocks after it is written as 1.
module ad9866_spi_slave
   import ad9866_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
`ifdef AD9866_SLV_DCCAL_EN
   ,
   parameter int unsigned CAL_CYCLES  = 1024
`endif
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sclk,
   input  logic         sen_n,
   input  logic         sdio,
   output logic         sdo,
   output logic         sdo_oe,
   output logic         wr_stb,
   output logic [4:0]   wr_addr,
   output logic [7:0]   wr_data,
   output logic         frame_err,
   output logic [255:0] regs_o
);

   logic sen_s;
   logic sdio_s;
   logic rise_c;
   logic fall_c;

   ad9866_spi_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sclk   (sclk),
      .sen_n  (sen_n),
      .sdio   (sdio),
      .sen_s  (sen_s),
      .sdio_s (sdio_s),
      .rise_c (rise_c),
      .fall_c (fall_c)
   );

   state_t                 state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [FRAME_BITS-2:0]  shreg;
   logic                   rd;
   logic [DATA_W-1:0]      rd_sr;
   logic [DATA_W-1:0]      regs [0:AD9866_NREGS-1];

   // Frame as it stands including the bit arriving with this rise
   logic [FRAME_BITS-1:0]  full_c;
   // Byte-count field is accepted but has no effect
   logic                   unused_nbytes_c;

   assign full_c          = {shreg, sdio_s};
   assign unused_nbytes_c = ^full_c[14:13];

`ifdef AD9866_SLV_DCCAL_EN
   localparam int unsigned CAL_W = $clog2(CAL_CYCLES + 1);
   logic [CAL_W-1:0] cal_cnt;
`endif

   // Frame FSM, register file and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         rd        <= 1'b0;
         rd_sr     <= '0;
         sdo       <= 1'b0;
         sdo_oe    <= 1'b0;
         wr_stb    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
         for (int a = 0; a < AD9866_NREGS; a++) begin
            regs[a] <= AD9866_REG_RST[a];
         end
`ifdef AD9866_SLV_DCCAL_EN
         cal_cnt   <= '0;
`endif
      end else begin
         wr_stb    <= 1'b0;
         frame_err <= 1'b0;

`ifdef AD9866_SLV_DCCAL_EN
         // Calibration timer; a write in the same cycle overrides below
         if (cal_cnt != '0) begin
            cal_cnt <= cal_cnt - CAL_W'(1);
            if (cal_cnt == CAL_W'(1)) begin
               regs[7][0] <= 1'b0;
            end
         end
`endif

         case (state)
            IDLE: begin
               bit_cnt <= '0;
               rd      <= 1'b0;
               if (!sen_s) begin
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               if (sen_s) begin
                  state     <= IDLE;
                  frame_err <= 1'b1;
                  sdo_oe    <= 1'b0;
                  sdo       <= 1'b0;
               end else if (rise_c) begin
                  shreg   <= full_c[FRAME_BITS-2:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  // Header complete: the low byte of full_c is R/nW, N, addr
                  if (bit_cnt == CNT_W'(7)) begin
                     rd    <= full_c[7];
                     rd_sr <= regs[full_c[4:0]];
                  end
                  if (bit_cnt == CNT_W'(15)) begin
                     state <= DONE;
                     if (!full_c[RW_BIT]) begin
                        regs[full_c[ADDR_MSB:ADDR_LSB]] <= full_c[DATA_W-1:0];
                        wr_stb  <= 1'b1;
                        wr_addr <= full_c[ADDR_MSB:ADDR_LSB];
                        wr_data <= full_c[DATA_W-1:0];
`ifdef AD9866_SLV_DCCAL_EN
                        if (full_c[ADDR_MSB:ADDR_LSB] == ADDR_W'(7)) begin
                           cal_cnt <= full_c[0] ? CAL_W'(CAL_CYCLES) : '0;
                        end
`endif
                     end
                  end
               end else if (fall_c && rd && (bit_cnt >= CNT_W'(8))) begin
                  // Falling edges 8..15 present read data MSB first
                  sdo    <= rd_sr[DATA_W-1];
                  rd_sr  <= {rd_sr[DATA_W-2:0], 1'b0};
                  sdo_oe <= 1'b1;
               end
            end

            DONE: begin
               if (sen_s) begin
                  state  <= IDLE;
                  sdo_oe <= 1'b0;
                  sdo    <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   for (genvar a = 0; a < AD9866_NREGS; a++) begin : g_regs_o
      assign regs_o[8*a +: 8] = regs[a];
   end

endmodule

// File: tb/tb_ad9866_spi_slave.sv
// Bench for ad9866_spi_slave: an SPI master driving directed and random frames,
// a register-map model updated from the frames the master sent, and a compare
// process that checks register file, write strobes and abort pulses each cycle.
module tb_ad9866_spi_slave;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sclk;
   logic         sen_n;
   logic         sdio;
   logic         sdo;
   logic         sdo_oe;
   logic         wr_stb;
   logic [4:0]   wr_addr;
   logic [7:0]   wr_data;
   logic         frame_err;
   logic [255:0] regs_o;

   always #5 clk = ~clk;

   ad9866_spi_slave dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (sclk),
      .sen_n     (sen_n),
      .sdio      (sdio),
      .sdo       (sdo),
      .sdo_oe    (sdo_oe),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .frame_err (frame_err),
      .regs_o    (regs_o)
   );

`ifdef AD9866_SLV_DCCAL_EN
   localparam int CAL = 1024;
   int cal_t = 0;
`endif

   logic [7:0] rst_tbl [0:31] = '{
      8'h80, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00,
      8'h00, 8'hF0, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   logic [7:0] mregs [0:31];
   wr_t        wq[$];
   int         err_pend = 0;
   int         n_wr = 0;
   int         n_err = 0;
   int         checks = 0;
   int         failures = 0;
   bit         rst_q = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      for (int a = 0; a < 32; a++) f[8*a +: 8] = mregs[a];
      return f;
   endfunction

   always @(posedge clk) rst_q <= rst_n;

   // Compare process: model follows the frames the master completed
   always @(negedge clk) begin
      if (!rst_q) begin
         for (int a = 0; a < 32; a++) mregs[a] = rst_tbl[a];
`ifdef AD9866_SLV_DCCAL_EN
         cal_t = 0;
`endif
      end else begin
`ifdef AD9866_SLV_DCCAL_EN
         if (cal_t > 0) begin
            cal_t--;
            if (cal_t == 0) mregs[7][0] = 1'b0;
         end
`endif
         if (wr_stb === 1'b1) begin
            wr_t e;
            n_wr++;
            if (wq.size() == 0) begin
               chk("spurious_wr_stb", 256'(wr_stb), 256'(0));
            end else begin
               e = wq.pop_front();
               chk("wr_addr", 256'(wr_addr), 256'(e.a));
               chk("wr_data", 256'(wr_data), 256'(e.d));
               mregs[e.a] = e.d;
`ifdef AD9866_SLV_DCCAL_EN
               if (e.a == 5'd7) cal_t = e.d[0] ? CAL : 0;
`endif
            end
         end
         if (frame_err === 1'b1) begin
            n_err++;
            chk("frame_err_expected", 256'(err_pend > 0), 256'(1));
            if (err_pend > 0) err_pend--;
         end
      end
      chk("regs_o", regs_o, model_flat());
   end

   // One master transfer of nbits bits (abort if < 16); returns captured read byte
   task automatic spi_frame(input logic [15:0] f, input int nbits, input int gap,
                            output logic [7:0] rdat);
      bit is_rd;
      is_rd = f[15];
      rdat  = '0;
      @(posedge clk); #1;
      sen_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < nbits; i++) begin
         sdio = f[15-i];
         repeat (2) @(posedge clk);
         #1;
         sclk = 1'b1;
         if (i == 15 && !is_rd) wq.push_back(wr_t'{f[12:8], f[7:0]});
         repeat (2) @(posedge clk);
         #1;
         if (i >= 8) rdat[15-i] = sdo;
         chk("sdo_oe_phase", 256'(sdo_oe), 256'(is_rd && i >= 8));
         sclk = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      if (nbits < 16) err_pend++;
      sen_n = 1'b1;
      sdio  = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  rdat;
      logic [7:0]  exp8;
      logic [15:0] init_seq [0:19];
      int          w0, e0;

      init_seq = '{16'h0080, 16'h0180, 16'h0200, 16'h0340, 16'h0400,
                   16'h0500, 16'h0600, 16'h0700, 16'h0801, 16'h0900,
                   16'h0a20, 16'h0b00, 16'h0c00, 16'h0d00, 16'h0e81,
                   16'h0f44, 16'h1000, 16'h1100, 16'h1220, 16'h130c};

      rst_n = 1'b0; sclk = 1'b0; sen_n = 1'b1; sdio = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_sdo", 256'(sdo), 256'(0));
      chk("rst_sdo_oe", 256'(sdo_oe), 256'(0));
      chk("rst_wr_stb", 256'(wr_stb), 256'(0));
      chk("rst_frame_err", 256'(frame_err), 256'(0));
      chk("rst_reg00", 256'(regs_o[7:0]), 256'(8'h80));
      chk("rst_reg0c", 256'(regs_o[103:96]), 256'(8'h1F));
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 1: single write
      w0 = n_wr; e0 = n_err;
      spi_frame(16'h0a4f, 16, 4, rdat);
      chk("t1_reg0a", 256'(regs_o[87:80]), 256'(8'h4f));
      chk("t1_one_wr", 256'(n_wr - w0), 256'(1));
      chk("t1_no_err", 256'(n_err - e0), 256'(0));

      // 2: read it back
      spi_frame(16'h8a00, 16, 4, rdat);
      chk("t2_read0a", 256'(rdat), 256'(8'h4f));
      chk("t2_oe_off", 256'(sdo_oe), 256'(0));

      // 3: aborted write after 10 bits
      w0 = n_wr; e0 = n_err;
      spi_frame(16'h0b20, 10, 4, rdat);
      chk("t3_reg0b", 256'(regs_o[95:88]), 256'(rst_tbl[11]));
      chk("t3_no_wr", 256'(n_wr - w0), 256'(0));
      chk("t3_one_err", 256'(n_err - e0), 256'(1));

      // 4: reset in the middle of a write frame
      spi_frame(16'h0c55, 16, 2, rdat);
      chk("t4_pre", 256'(regs_o[103:96]), 256'(8'h55));
      @(posedge clk); #1;
      sen_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         logic [15:0] fr;
         fr = 16'h0c43;
         sdio = fr[15-i];
         repeat (2) @(posedge clk);
         #1; sclk = 1'b1;
         repeat (2) @(posedge clk);
         #1; sclk = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      sen_n = 1'b1; sdio = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t4_reg0c_rst", 256'(regs_o[103:96]), 256'(8'h1F));
      spi_frame(16'h0c43, 16, 3, rdat);
      spi_frame(16'h8c00, 16, 3, rdat);
      chk("t4_read0c", 256'(rdat), 256'(8'h43));

      // 5: back-to-back init sequence with 1-clk gaps
      foreach (init_seq[k]) spi_frame(init_seq[k], 16, 1, rdat);
      repeat (6) @(posedge clk);
      #1;
      chk("t5_reg0e", 256'(regs_o[119:112]), 256'(8'h81));
      chk("t5_reg13", 256'(regs_o[159:152]), 256'(8'h0c));
      chk("t5_reg0f", 256'(regs_o[127:120]), 256'(8'h44));

`ifdef AD9866_SLV_DCCAL_EN
      // 6: self-clearing calibration bit
      spi_frame(16'h0721, 16, 2, rdat);
      chk("t6_bit0_set", 256'(regs_o[63:56]), 256'(8'h21));
      repeat (CAL + 4) @(posedge clk);
      #1;
      chk("t6_bit0_clr", 256'(regs_o[63:56]), 256'(8'h20));
`endif

      // Random mix of writes, reads and aborts
      for (int n = 0; n < 60; n++) begin
         int          kind;
         logic [4:0]  a;
         logic [7:0]  d;
         kind = $urandom_range(0, 9);
         a    = 5'($urandom_range(0, 31));
         d    = 8'($urandom);
         if (a == 5'd7) d[0] = 1'b0;
         if (kind == 0) begin
            spi_frame({1'($urandom_range(0, 1)), 2'b00, a, d},
                      $urandom_range(1, 15), $urandom_range(1, 4), rdat);
         end else if (kind <= 4) begin
            exp8 = mregs[a];
            spi_frame({1'b1, 2'($urandom_range(0, 3)), a, d}, 16,
                      $urandom_range(1, 4), rdat);
            chk("rnd_read", 256'(rdat), 256'(exp8));
         end else begin
            spi_frame({1'b0, 2'($urandom_range(0, 3)), a, d}, 16,
                      $urandom_range(1, 4), rdat);
         end
      end

      repeat (10) @(posedge clk);
      #1;
      chk("end_wr_queue_empty", 256'(wq.size()), 256'(0));
      chk("end_err_pending", 256'(err_pend), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
